// File: rtl/brtgt_gen_pkg.sv
// Shared constants for the branch-target generator: field widths, RV32 control-flow
// opcodes and the 2-bit control-flow kind encoding.
package brtgt_gen_pkg;

  localparam int INSN_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;

  localparam logic [6:0] RV32_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_BR   = 2'b01,
    KIND_JAL  = 2'b10,
    KIND_JALR = 2'b11
  } kind_e;

endpackage

// File: rtl/brtgt_gen_if.sv
// Bundle-level handshake between the fetch queue, the branch-target generator and its
// consumer. Lane k of every flattened field sits at [k*WIDTH +: WIDTH].
interface brtgt_gen_if #(parameter int LANES = 2);
  import brtgt_gen_pkg::*;

  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             in_lane_vld;
  logic [LANES*INSN_LEN-1:0]    in_inst;
  logic [LANES*ADDR_LEN-1:0]    in_pc;

  logic                         out_valid;
  logic                         out_ready;
  logic [LANES-1:0]             out_lane_vld;
  logic [LANES*2-1:0]           out_kind;
  logic [LANES*DATA_LEN-1:0]    out_brimm;
  logic [LANES*ADDR_LEN-1:0]    out_target;
  logic                         out_jal_hit;
  logic [1:0]                   out_jal_lane;
  logic [ADDR_LEN-1:0]          out_jal_tgt;

  modport master (
    output flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_lane_vld, out_kind, out_brimm, out_target,
           out_jal_hit, out_jal_lane, out_jal_tgt
  );

  modport slave (
    input  flush, in_valid, in_lane_vld, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_lane_vld, out_kind, out_brimm, out_target,
           out_jal_hit, out_jal_lane, out_jal_tgt
  );

endinterface

// File: rtl/brtgt_gen_lane.sv
// One decode lane: classifies a control-flow instruction, extracts its sign-extended
// immediate and forms the PC-relative target. Purely combinational.
module brtgt_lane
  import brtgt_gen_pkg::*;
(
  input  logic                vld_i,
  input  logic [INSN_LEN-1:0] inst_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output kind_e               kind_o,
  output logic [DATA_LEN-1:0] imm_o,
  output logic [ADDR_LEN-1:0] target_o
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    kind_o   = KIND_NONE;
    imm_o    = '0;
    target_o = '0;
    if (vld_i) begin
      unique case (inst_i[6:0])
        RV32_BRANCH: begin
          kind_o   = KIND_BR;
          imm_o    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
          target_o = pc_i + imm_o;
        end
        RV32_JAL: begin
          kind_o   = KIND_JAL;
          imm_o    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
          target_o = pc_i + imm_o;
        end
        // JALR target depends on rs1, so only the immediate is produced here.
        RV32_JALR: begin
          kind_o = KIND_JALR;
          imm_o  = {{20{inst_i[31]}}, inst_i[31:20]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/brtgt_gen.sv
// Multi-lane branch-target generator: per-lane decode feeding a main register plus a
// one-entry skid buffer, with lowest-lane JAL detection for early front-end redirect.
module brtgt_gen
  import brtgt_gen_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        reset,
  brtgt_gen_if.slave  bus
);

  typedef struct packed {
    logic [LANES-1:0]               vld;
    logic [LANES-1:0][1:0]          kind;
    logic [LANES-1:0][DATA_LEN-1:0] imm;
    logic [LANES-1:0][ADDR_LEN-1:0] tgt;
  } bundle_t;

  wire [LANES-1:0][1:0]          dec_kind;
  wire [LANES-1:0][DATA_LEN-1:0] dec_imm;
  wire [LANES-1:0][ADDR_LEN-1:0] dec_tgt;
  bundle_t                       dec;

  bundle_t m_q, m_d, s_q, s_d;
  logic    vm_q, vm_d, vs_q, vs_d;
  logic    out_xfer;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    brtgt_lane u_lane (
      .vld_i    (bus.in_lane_vld[k]),
      .inst_i   (bus.in_inst[k*INSN_LEN +: INSN_LEN]),
      .pc_i     (bus.in_pc[k*ADDR_LEN +: ADDR_LEN]),
      .kind_o   (dec_kind[k]),
      .imm_o    (dec_imm[k]),
      .target_o (dec_tgt[k])
    );
  end

  always_comb begin
    dec.vld  = bus.in_lane_vld;
    dec.kind = dec_kind;
    dec.imm  = dec_imm;
    dec.tgt  = dec_tgt;
  end

  assign out_xfer = vm_q & bus.out_ready;

  // Skid occupancy alone gates acceptance, keeping in_ready free of any out_ready path.
  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    vm_d = vm_q;
    vs_d = vs_q;
    if (bus.flush) begin
      vm_d = 1'b0;
      vs_d = 1'b0;
    end else if (vs_q) begin
      if (out_xfer) begin
        m_d  = s_q;
        vs_d = 1'b0;
      end
    end else if (!vm_q || out_xfer) begin
      vm_d = bus.in_valid;
      if (bus.in_valid) m_d = dec;
    end else if (bus.in_valid) begin
      s_d  = dec;
      vs_d = 1'b1;
    end
  end

  // NOTE: the data registers are reset as well as the valid bits because the outputs
  // must read zero out of reset, not merely be marked invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vm_q <= 1'b0;
      vs_q <= 1'b0;
      m_q  <= '0;
      s_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vm_q <= vm_d;
      vs_q <= vs_d;
      m_q  <= m_d;
      s_q  <= s_d;
    end
  end

  // Scan from the top lane down so the lowest matching lane is the one left standing.
  always_comb begin
    bus.out_jal_hit  = 1'b0;
    bus.out_jal_lane = '0;
    bus.out_jal_tgt  = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m_q.vld[k] && (m_q.kind[k] == KIND_JAL)) begin
        bus.out_jal_hit  = 1'b1;
        bus.out_jal_lane = 2'(k);
        bus.out_jal_tgt  = m_q.tgt[k];
      end
    end
  end

  assign bus.in_ready     = ~vs_q;
  assign bus.out_valid    = vm_q;
  assign bus.out_lane_vld = m_q.vld;
  assign bus.out_kind     = m_q.kind;
  assign bus.out_brimm    = m_q.imm;
  assign bus.out_target   = m_q.tgt;

endmodule

// File: doc/brtgt_gen.md
Name: brtgt_gen

Overview:
- Parametrised, pipelined successor to the single-lane combinational branch-immediate generator.
- Decodes LANES instructions per cycle from the fetch/decode boundary. For each lane it produces:
  - the sign-extended control-flow immediate,
  - the statically computable target PC,
  - a control-flow kind.
- Registers results behind a valid/ready handshake with a skid buffer, and flags the lowest-lane JAL for early front-end redirect.
- Sits between the fetch queue and the decoder/branch-predictor update logic.

Parameters:
- LANES, 2, instructions decoded per cycle (1..4).
- INSN_LEN, 32, instruction width.
- DATA_LEN, 32, immediate width.
- ADDR_LEN, 32, PC width.

Ports:
- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-low
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  input bundle valid
- in_ready  output  1  block can accept bundle
- in_lane_vld  input  LANES  per-lane valid mask
- in_inst  input  LANES*INSN_LEN  lane k at [k*INSN_LEN +: INSN_LEN]
- in_pc  input  LANES*ADDR_LEN  lane k PC
- out_valid  output  1  output bundle valid
- out_ready  input  1  consumer accepts bundle
- out_lane_vld  output  LANES  registered lane mask
- out_kind  output  LANES*2  per lane: 00 none, 01 BRANCH, 10 JAL, 11 JALR
- out_brimm  output  LANES*DATA_LEN  sign-extended immediate
- out_target  output  LANES*ADDR_LEN  pc+imm (BRANCH/JAL), 0 otherwise
- out_jal_hit  output  1  some valid lane is JAL
- out_jal_lane  output  2  lowest such lane index
- out_jal_tgt  output  ADDR_LEN  that lane's target

Behaviour:
- Handshakes: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.

Decode (combinational, per lane, opcode = inst[6:0]):
- BRANCH: imm = {20{i[31]},i[7],i[30:25],i[11:8],0}.
- JAL: imm = {12{i[31]},i[19:12],i[20],i[30:21],0}.
- JALR: imm = {20{i[31]},i[31:20]}. This is the full 12-bit I-immediate, replacing the old truncated form.
- Other opcodes, or lane masked off: kind=00, imm=0, target=0.
- target = pc + imm, modulo 2^ADDR_LEN (wrap silently). JALR target is 0 because it needs rs1.

Pipeline:
- Main register M plus skid register S, one bundle each; valid bits vM, vS.
- Latency: exactly 1 cycle from input transfer to out_valid, when not stalled.
- in_ready = ~vS. It is a pure register output with no combinational path from out_ready.
- Input transfer when M is empty or drains this cycle: the bundle goes to M.
- Input transfer while M is held: the bundle goes to S.
- Output transfer with vS=1: S moves to M, vS clears. The same cycle, the new input is accepted only if vS was 0 at the start of the cycle.
- Ordering is strictly FIFO. Bundles are never dropped or duplicated.
- out_* fields reflect M; out_valid = vM.

JAL detection:
- Computed combinationally from M.
- out_jal_hit=1 iff some lane with out_lane_vld=1 has kind=10.
- out_jal_lane = lowest such index; out_jal_tgt = its target.
- When hit=0, lane=0 and tgt=0.

Flush:
- Next cycle vM=vS=0.
- An input presented in the same cycle as flush is discarded. in_ready remains as computed, so the upstream sees the transfer completed.
- flush has priority over out_ready.

Reset and stability:
- Reset clears vM and vS. All out_* data fields read 0, out_valid=0, in_ready=1.
- Reset asserted mid-stall discards both entries immediately.
- While out_valid=1 and out_ready=0, all out_* fields stay stable.

Decomposition:
- Shared package/header holds:
  - the opcode constants RV32_BRANCH/JAL/JALR,
  - the KIND_NONE/BR/JAL/JALR 2-bit encodings,
  - INSN_LEN/DATA_LEN/ADDR_LEN.
- Sub-module brtgt_lane is natural. It is purely combinational: one lane's inst and pc in; kind, imm and target out. The top instantiates it LANES times and holds the M/S registers plus the JAL priority encoder.

Test Plan:
1. LANES=2, lane0 inst 0xFE000CE3 (beq -8) at pc 0x100 -> next cycle out_kind0=01, brimm0=0xFFFFFFF8, target0=0x000000F8.
2. lane1 inst 0x001000EF (jal +2048) at pc 0x1000, lane0 same JAL at 0x0 but masked -> out_jal_hit=1, out_jal_lane=1, out_jal_tgt=0x1800.
3. inst 0xFFC08067 (jalr -4) -> kind=11, brimm=0xFFFFFFFC, target=0, jal_hit=0.
4. Hold out_ready=0, push 2 bundles -> in_ready=0 after the second and outputs stable. Raise out_ready -> bundles emerge in order on consecutive cycles and in_ready returns to 1.
5. Boundary wrap: beq -8 at pc 0x4 -> target 0xFFFFFFFC. Flush with M and S full plus in_valid -> next cycle out_valid=0 and the input is lost.
6. Assert reset (low) mid-stall -> out_valid=0 and in_ready=1 immediately, out_* data 0.
